// File: rtl/hazard_scoreboard.sv
// Register-write hazard scoreboard: one 2-bit pending-write counter per GPR x1..x31.
// Optional stall statistics counter enabled by defining SCOREBOARD_STATS_EN.
module hazard_scoreboard #(
  parameter int MAX_INFL = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_use_rs1_i,
  input  logic        id_use_rs2_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_wr_rd_i,
  output logic        id_stall_o,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        flush_i,
`ifdef SCOREBOARD_STATS_EN
  output logic [31:0] stall_cnt_o,
`endif
  output logic        busy_o,
  output logic        err_o
);

  localparam logic [1:0] MaxCnt = 2'(MAX_INFL);

  logic [1:0]  cnt_q [1:31];
  logic [1:0]  cnt_d [1:31];
  logic        err_q, err_d;

  logic [31:0] pend_vec;
  logic [31:0] full_vec;
  logic [31:0] issue_vec;
  logic [31:0] retire_vec;

  logic        rs1_hit, rs2_hit, rd_full;
  logic        issue, retire;
  logic        underflow;

  // x0 never has a counter, so its pending/full bits are tied low.
  assign pend_vec[0] = 1'b0;
  assign full_vec[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_vec
      assign pend_vec[gi] = (cnt_q[gi] != 2'd0);
      assign full_vec[gi] = (cnt_q[gi] == MaxCnt);
    end
  endgenerate

  // Stall looks only at registered counters; a same-cycle retire does not bypass.
  assign rs1_hit = id_use_rs1_i & (id_rs1_i != 5'd0) & pend_vec[id_rs1_i];
  assign rs2_hit = id_use_rs2_i & (id_rs2_i != 5'd0) & pend_vec[id_rs2_i];
  assign rd_full = id_wr_rd_i   & (id_rd_i  != 5'd0) & full_vec[id_rd_i];

  assign id_stall_o = id_valid_i & (rs1_hit | rs2_hit | rd_full);

  assign issue  = id_valid_i & ~id_stall_o & id_wr_rd_i & (id_rd_i != 5'd0);
  assign retire = wb_valid_i & (wb_rd_i != 5'd0);

  assign issue_vec  = issue  ? (32'd1 << id_rd_i) : 32'd0;
  assign retire_vec = retire ? (32'd1 << wb_rd_i) : 32'd0;

  always_comb begin
    underflow = 1'b0;
    for (int i = 1; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush_i) begin
        cnt_d[i] = 2'd0;
      end else if (issue_vec[i] && !retire_vec[i]) begin
        cnt_d[i] = cnt_q[i] + 2'd1;
      end else if (retire_vec[i] && !issue_vec[i]) begin
        if (cnt_q[i] == 2'd0) begin
          underflow = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - 2'd1;
        end
      end
    end
  end

  // A retire swallowed by a flush is discarded, so it cannot raise the error.
  assign err_d = err_q | (underflow & ~flush_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < 32; i++) begin
        cnt_q[i] <= 2'd0;
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      err_q <= err_d;
    end
  end

  assign busy_o = |pend_vec;
  assign err_o  = err_q;

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt_d = stall_cnt_q + {31'd0, id_stall_o};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: RAW, x0, saturation, simultaneous events, flush, reset.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic        id_use_rs1_i, id_use_rs2_i, id_wr_rd_i;
  logic        id_stall_o;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic        flush_i;
  logic        busy_o;
  logic        err_o;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  hazard_scoreboard #(.MAX_INFL(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid_i   (id_valid_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_use_rs1_i (id_use_rs1_i),
    .id_use_rs2_i (id_use_rs2_i),
    .id_rd_i      (id_rd_i),
    .id_wr_rd_i   (id_wr_rd_i),
    .id_stall_o   (id_stall_o),
    .wb_valid_i   (wb_valid_i),
    .wb_rd_i      (wb_rd_i),
    .flush_i      (flush_i),
`ifdef SCOREBOARD_STATS_EN
    .stall_cnt_o  (stall_cnt_o),
`endif
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic idle();
    id_valid_i   = 1'b0;
    id_rs1_i     = 5'd0;
    id_rs2_i     = 5'd0;
    id_rd_i      = 5'd0;
    id_use_rs1_i = 1'b0;
    id_use_rs2_i = 1'b0;
    id_wr_rd_i   = 1'b0;
    wb_valid_i   = 1'b0;
    wb_rd_i      = 5'd0;
    flush_i      = 1'b0;
  endtask

  // Inputs change 1ns after the rising edge; checks happen 2ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_write(input logic [4:0] rd);
    id_valid_i = 1'b1;
    id_wr_rd_i = 1'b1;
    id_rd_i    = rd;
  endtask

  task automatic drive_read(input logic [4:0] rs);
    id_valid_i   = 1'b1;
    id_use_rs1_i = 1'b1;
    id_rs1_i     = rs;
  endtask

  task automatic drive_wb(input logic [4:0] rd);
    wb_valid_i = 1'b1;
    wb_rd_i    = rd;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    step(); step();
    settle();
    check("reset_stall", {31'd0, id_stall_o}, 32'd0);
    check("reset_busy",  {31'd0, busy_o},     32'd0);
    check("reset_err",   {31'd0, err_o},      32'd0);
    rst = 1'b1;

    // RAW on x5
    step(); idle(); drive_write(5'd5); settle();
    check("raw_issue_nostall", {31'd0, id_stall_o}, 32'd0);
    step(); idle(); drive_read(5'd5); settle();
    check("raw_busy", {31'd0, busy_o}, 32'd1);
    check("raw_stall_1", {31'd0, id_stall_o}, 32'd1);
    step(); settle();
    check("raw_stall_2", {31'd0, id_stall_o}, 32'd1);
    step(); drive_wb(5'd5); settle();
    check("raw_stall_same_cycle_wb", {31'd0, id_stall_o}, 32'd1);
    step(); wb_valid_i = 1'b0; settle();
    check("raw_release", {31'd0, id_stall_o}, 32'd0);
    check("raw_busy_clear", {31'd0, busy_o}, 32'd0);

    // x0 is never pending
    step(); idle(); drive_write(5'd0); settle();
    check("x0_issue_nostall", {31'd0, id_stall_o}, 32'd0);
    step(); idle(); drive_read(5'd0); settle();
    check("x0_read_nostall", {31'd0, id_stall_o}, 32'd0);
    check("x0_busy", {31'd0, busy_o}, 32'd0);

    // Saturation on x7
    for (int k = 0; k < 3; k++) begin
      step(); idle(); drive_write(5'd7); settle();
      check($sformatf("sat_issue_%0d", k), {31'd0, id_stall_o}, 32'd0);
    end
    step(); settle();
    check("sat_4th_stall", {31'd0, id_stall_o}, 32'd1);
    drive_wb(5'd7);
    step(); wb_valid_i = 1'b0; settle();
    check("sat_4th_proceeds", {31'd0, id_stall_o}, 32'd0);
    step(); settle();
    check("sat_full_again", {31'd0, id_stall_o}, 32'd1);
    idle();
    for (int k = 0; k < 3; k++) begin
      step(); idle(); drive_wb(5'd7);
    end
    step(); idle(); settle();
    check("sat_drained_busy", {31'd0, busy_o}, 32'd0);
    check("sat_no_err", {31'd0, err_o}, 32'd0);

    // Simultaneous issue and retire on x9
    step(); idle(); drive_write(5'd9);
    step(); drive_wb(5'd9); settle();
    check("sim_issue_allowed", {31'd0, id_stall_o}, 32'd0);
    step(); idle(); drive_read(5'd9); settle();
    check("sim_read_stalls", {31'd0, id_stall_o}, 32'd1);
    check("sim_busy", {31'd0, busy_o}, 32'd1);
    drive_wb(5'd9);
    step(); wb_valid_i = 1'b0; settle();
    check("sim_read_released", {31'd0, id_stall_o}, 32'd0);
    check("sim_busy_clear", {31'd0, busy_o}, 32'd0);

    // Flush with x3=2, x4=1, plus a same-cycle issue to x4 that must be dropped
    step(); idle(); drive_write(5'd3);
    step(); idle(); drive_write(5'd3);
    step(); idle(); drive_write(5'd4);
    step(); idle(); drive_read(5'd3); settle();
    check("flush_pre_stall", {31'd0, id_stall_o}, 32'd1);
    idle(); drive_write(5'd4); flush_i = 1'b1;
    step(); idle(); drive_read(5'd3); settle();
    check("flush_busy", {31'd0, busy_o}, 32'd0);
    check("flush_read_nostall", {31'd0, id_stall_o}, 32'd0);
    check("flush_err_untouched", {31'd0, err_o}, 32'd0);
    idle(); drive_wb(5'd3);
    step(); idle(); settle();
    check("underflow_err", {31'd0, err_o}, 32'd1);
    check("underflow_busy", {31'd0, busy_o}, 32'd0);
    step(); step(); settle();
    check("err_sticky", {31'd0, err_o}, 32'd1);

    // Asynchronous reset mid-operation with x12 pending
    step(); idle(); drive_write(5'd12);
    step(); idle(); drive_read(5'd12); settle();
    check("mid_busy_before", {31'd0, busy_o}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("mid_busy", {31'd0, busy_o}, 32'd0);
    check("mid_err", {31'd0, err_o}, 32'd0);
    check("mid_stall", {31'd0, id_stall_o}, 32'd0);
`ifdef SCOREBOARD_STATS_EN
    check("mid_stall_cnt", stall_cnt_o, 32'd0);
`endif
    #1 rst = 1'b1;
    step(); settle();
    check("post_reset_stall", {31'd0, id_stall_o}, 32'd0);
    check("post_reset_busy", {31'd0, busy_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter MAX_INFL, default 3, giving the maximum in-flight writes per register (legal 1..3); the counter width is 2 bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port id_valid_i, input, 1, meaning the ID stage holds a valid instruction.
REQ-005 SHALL have ports id_rs1_i and id_rs2_i, input, 5 each, the decoded source register specifiers.
REQ-006 SHALL have ports id_use_rs1_i and id_use_rs2_i, input, 1 each, meaning the instruction reads that source.
REQ-007 SHALL have port id_rd_i, input, 5, the decoded destination specifier.
REQ-008 SHALL have port id_wr_rd_i, input, 1, meaning the instruction writes rd.
REQ-009 SHALL have port id_stall_o, output, 1, which holds ID/IF and inserts a bubble into EX.
REQ-010 SHALL have ports wb_valid_i (input, 1) and wb_rd_i (input, 5), the WB register-file write that retires a pending write.
REQ-011 SHALL have port flush_i, input, 1, the pipeline flush (branch or exception).
REQ-012 SHALL have port busy_o, output, 1, meaning at least one register has a nonzero counter.
REQ-013 SHALL have port err_o, output, 1, a sticky retire-underflow error flag.

Function
REQ-014 SHALL keep one 2-bit pending counter per register x1..x31; x0 has no counter and is never pending.
REQ-015 SHALL compute id_stall_o combinationally from registered counters only: id_valid_i & ((id_use_rs1_i & rs1!=0 & cnt[rs1]!=0) | (id_use_rs2_i & rs2!=0 & cnt[rs2]!=0) | (id_wr_rd_i & rd!=0 & cnt[rd]==MAX_INFL)).
REQ-016 SHALL NOT bypass a same-cycle WB retire: a source whose counter is retired this cycle still stalls this cycle and releases the next cycle.
REQ-017 SHALL define issue = id_valid_i & !id_stall_o & id_wr_rd_i & id_rd_i!=0; an issue increments cnt[id_rd_i] at the next edge.
REQ-018 SHALL define retire = wb_valid_i & wb_rd_i!=0; a retire decrements cnt[wb_rd_i] at the next edge.
REQ-019 SHALL leave the counter unchanged when an issue and a retire target the same register in the same cycle.
REQ-020 SHALL treat a retire to a counter of 0 as an underflow: the counter stays 0 and err_o sets and holds until reset.
REQ-021 SHALL never wrap a counter; saturation is prevented by the MAX_INFL stall term in REQ-015.
REQ-022 SHALL, when flush_i=1, clear all counters at the next edge; flush overrides any same-cycle issue or retire, and err_o is unaffected.
REQ-023 SHALL relay a WB retire that follows a flush only for non-flushed instructions; the WB requester guarantees this.
REQ-024 SHALL drive busy_o as the OR of all counters being nonzero, from registered state.
REQ-025 SHALL have zero-cycle stall latency (combinational) and one-cycle update latency for issue, retire and flush.

Reset
REQ-026 SHALL, on rst low, asynchronously clear all counters and err_o (and stall_cnt_o when present); id_stall_o=0, busy_o=0 and err_o=0 during and after reset.
REQ-027 SHALL discard all in-flight tracking when reset asserts mid-operation, with no outstanding state retained.

Configuration
REQ-028 SHALL, with SCOREBOARD_STATS_EN defined, add output stall_cnt_o (32-bit), which increments on every cycle id_stall_o=1, wraps 0xFFFFFFFF to 0, is unaffected by flush_i, and is cleared by rst.
REQ-029 SHALL, without SCOREBOARD_STATS_EN, omit both the port and the counter; all other behaviour is identical.

Verification
REQ-030 SHALL cover RAW: issue rd=x5; next cycle rs1=x5 with use_rs1 -> id_stall_o=1 until the cycle after wb_rd_i=5, then 0.
REQ-031 SHALL cover x0: issue rd=x0, then read rs1=x0 -> never stalls, and busy_o stays 0.
REQ-032 SHALL cover saturation: 3 issues to x7 with no retire, then a 4th issue to x7 -> id_stall_o=1; one retire of x7 -> the 4th issue proceeds the next cycle.
REQ-033 SHALL cover simultaneous events: cnt[x9]=1, same-cycle issue x9 and retire x9 -> cnt[x9] stays 1 and a read of x9 still stalls.
REQ-034 SHALL cover flush: counters x3=2 and x4=1, then flush_i -> the next cycle busy_o=0 and a read of x3 does not stall; a retire to x3 then -> err_o=1.
REQ-035 SHALL cover reset mid-operation: rst low with busy_o=1 -> busy_o, err_o and id_stall_o are 0 immediately (asynchronous), and stall_cnt_o=0 when SCOREBOARD_STATS_EN is defined.
